// File: rtl/pixel_timing_if.sv
// Pixel timing bus between the raster timing generator and its consumers.
// Ports (generator view, modport master):
//   en          in   run enable; 0 freezes the generator
//   pix_en      out  one-clk pixel enable pulse
//   x, y        out  raster position
//   video_on    out  visible-area flag
//   hsync/vsync out  sync outputs at their configured polarity
//   line_start  out  one-clk strobe on entry to x=0
//   frame_start out  one-clk strobe on entry to (0,0)
interface pixel_timing_if #(
   parameter int unsigned X_W = 10,
   parameter int unsigned Y_W = 10
);
   logic           en;
   logic           pix_en;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           video_on;
   logic           hsync;
   logic           vsync;
   logic           line_start;
   logic           frame_start;

   modport master (
      input  en,
      output pix_en, x, y, video_on, hsync, vsync, line_start, frame_start
   );

   modport slave (
      output en,
      input  pix_en, x, y, video_on, hsync, vsync, line_start, frame_start
   );
endinterface

// File: rtl/pixel_timing_gen.sv
// Pixel-rate enable and raster timing generator for the VGA display path.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  pixel_timing_if.master: en in; pix_en, x, y, video_on, hsync,
//        vsync, line_start, frame_start out (all registered)
// The interface X_W/Y_W must match this module's X_W/Y_W.
module pixel_timing_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned X_W      = 10,
   parameter int unsigned Y_W      = 10
) (
   input  logic            clk,
   input  logic            rst,
   pixel_timing_if.master  bus
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0]   X_ACT    = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0]   HS_FIRST = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0]   HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0]   Y_ACT    = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0]   VS_FIRST = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0]   VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             pix_en_q, pix_en_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic             video_on_q, video_on_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;

   // Divider, position advance, and region decode of the next position
   always_comb begin
      div_cnt_d     = div_cnt_q;
      pix_en_d      = 1'b0;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (bus.en) begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
         pix_en_d  = (div_cnt_q == DIV_LAST);
      end

      // A pulse already issued is always consumed, even if en drops on this
      // edge, so a pause lengthens the line by exactly the paused clocks.
      if (pix_en_q) begin
         if (x_q == X_LAST) begin
            x_d          = '0;
            y_d          = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            line_start_d = 1'b1;
            frame_start_d = (y_q == Y_LAST);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end

      video_on_d = (x_d < X_ACT) && (y_d < Y_ACT);
      hsync_d    = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync_d    = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
   end

   // State and output registers; reset parks at the back-porch corner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q     <= '0;
         pix_en_q      <= 1'b0;
         x_q           <= X_LAST;
         y_q           <= Y_LAST;
         video_on_q    <= 1'b0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pix_en_q      <= pix_en_d;
         x_q           <= x_d;
         y_q           <= y_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.pix_en      = pix_en_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.video_on    = video_on_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Self-checking bench for pixel_timing_gen: default VGA timing (dut_a) and a
// tiny raster with CLK_DIV=1 and active-high hsync (dut_b).
module tb_pixel_timing_gen;

   typedef struct {
      int d, ha, hf, hs, hb, va, vf, vs, vb;
      bit hp, vp;
   } cfg_t;

   typedef struct packed {
      bit pix; int x; int y; bit vo; bit hs; bit vs; bit ls; bit fs;
   } obs_t;

   typedef struct packed {
      bit   en;
      obs_t exp;
   } vec_t;

   logic clk;
   logic rst_a, rst_b;

   pixel_timing_if #(.X_W(10), .Y_W(10)) bus_a ();
   pixel_timing_if #(.X_W(3),  .Y_W(3))  bus_b ();

   pixel_timing_gen dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   pixel_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .X_W(3), .Y_W(3)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   cfg_t  cfg[2];
   // en=1 edge counts after the latest edge, the one before, and the one before that
   longint k0[2], k1[2], k2[2];
   bit    en_last[2];
   vec_t  tbl[8];

   // Reference: the number of advances equals the number of divider wraps seen
   // on earlier edges; position follows from that count by plain arithmetic.
   function automatic obs_t model_obs(cfg_t c, longint kn, longint kp, longint kpp, bit en_n);
      obs_t   o;
      int     ht = c.ha + c.hf + c.hs + c.hb;
      int     vt = c.va + c.vf + c.vs + c.vb;
      longint a  = kp / c.d;
      longint ap = kpp / c.d;
      longint p  = -1;
      bit     adv = (a != ap);
      if (a == 0) begin
         o.x = ht - 1;
         o.y = vt - 1;
      end else begin
         p   = (a - 1) % (ht * vt);
         o.x = int'(p % ht);
         o.y = int'(p / ht);
      end
      o.pix = en_n && (kn % c.d == 0);
      o.vo  = (o.x < c.ha) && (o.y < c.va);
      o.hs  = (o.x >= c.ha + c.hf && o.x < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
      o.vs  = (o.y >= c.va + c.vf && o.y < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
      o.ls  = adv && (o.x == 0);
      o.fs  = adv && (p == 0);
      return o;
   endfunction

   function automatic obs_t read_dut(int id);
      obs_t o;
      if (id == 0) begin
         o = '{bus_a.pix_en, int'(bus_a.x), int'(bus_a.y), bus_a.video_on,
               bus_a.hsync, bus_a.vsync, bus_a.line_start, bus_a.frame_start};
      end else begin
         o = '{bus_b.pix_en, int'(bus_b.x), int'(bus_b.y), bus_b.video_on,
               bus_b.hsync, bus_b.vsync, bus_b.line_start, bus_b.frame_start};
      end
      return o;
   endfunction

   task automatic cmp_obs(string name, obs_t got, obs_t want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s t=%0t got pix=%0d x=%0d y=%0d vo=%0d hs=%0d vs=%0d ls=%0d fs=%0d want pix=%0d x=%0d y=%0d vo=%0d hs=%0d vs=%0d ls=%0d fs=%0d",
                  name, $time, got.pix, got.x, got.y, got.vo, got.hs, got.vs, got.ls, got.fs,
                  want.pix, want.x, want.y, want.vo, want.hs, want.vs, want.ls, want.fs);
      end
   endtask

   task automatic chk_int(string name, int got, int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
      end
   endtask

   task automatic check_model(int id, string name);
      cmp_obs(name, read_dut(id), model_obs(cfg[id], k0[id], k1[id], k2[id], en_last[id]));
   endtask

   task automatic model_reset(int id);
      k0[id] = 0; k1[id] = 0; k2[id] = 0; en_last[id] = 1'b0;
   endtask

   // Called at a negedge: drive en, take one edge, compare at the next negedge
   task automatic step(int id, bit en_v, string name);
      if (id == 0) bus_a.en = en_v; else bus_b.en = en_v;
      @(posedge clk);
      k2[id] = k1[id];
      k1[id] = k0[id];
      if (en_v) k0[id] = k0[id] + 1;
      en_last[id] = en_v;
      @(negedge clk);
      check_model(id, name);
   endtask

   task automatic run_table();
      for (int i = 0; i < 8; i++) begin
         step(0, tbl[i].en, "tbl_model");
         cmp_obs($sformatf("tbl_%0d", i), read_dut(0), tbl[i].exp);
      end
   endtask

   initial begin
      int ls_seen, t_ls1, t_ls2, hs_low, hs_min, hs_max, vo_fall, cnt, bad;
      int fs_cnt, fs_prev, fs_ival, pix_bad, hs_bad, vs_bad;
      bit vo_prev, found;

      cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
      cfg[1] = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0};
      model_reset(0);
      model_reset(1);
      // Expected values after each edge following reset release, defaults
      tbl[0] = '{1'b1, '{1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[1] = '{1'b1, '{1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[2] = '{1'b1, '{1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
      tbl[3] = '{1'b1, '{1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[4] = '{1'b1, '{1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[5] = '{1'b0, '{1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[6] = '{1'b1, '{1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[7] = '{1'b1, '{1'b0,   2,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};

      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.en = 1'b1; bus_b.en = 1'b1;
      repeat (3) @(negedge clk);
      check_model(0, "reset_a");
      rst_a = 1'b0;
      run_table();

      // One full line: sync window, blanking start, line period
      ls_seen = 0; t_ls1 = 0; t_ls2 = 0; hs_low = 0; hs_min = 9999; hs_max = -1;
      vo_fall = -1; vo_prev = bus_a.video_on;
      for (int i = 0; i < 4000 && ls_seen < 2; i++) begin
         step(0, 1'b1, "line");
         if (bus_a.line_start) begin
            ls_seen++;
            if (ls_seen == 1) t_ls1 = i; else t_ls2 = i;
         end
         if (ls_seen == 1) begin
            if (!bus_a.hsync) begin
               hs_low++;
               if (int'(bus_a.x) < hs_min) hs_min = int'(bus_a.x);
               if (int'(bus_a.x) > hs_max) hs_max = int'(bus_a.x);
            end
            if (vo_prev && !bus_a.video_on && vo_fall < 0) vo_fall = int'(bus_a.x);
         end
         vo_prev = bus_a.video_on;
      end
      chk_int("line_starts_seen", ls_seen, 2);
      chk_int("line_period", t_ls2 - t_ls1, 1600);
      chk_int("hsync_low_clks", hs_low, 192);
      chk_int("hsync_first_x", hs_min, 656);
      chk_int("hsync_last_x", hs_max, 751);
      chk_int("video_off_x", vo_fall, 640);

      // Pause 37 clocks at x=100; the line must grow by exactly that much
      cnt = 0; found = 1'b0; bad = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step(0, 1'b1, "to_x100");
         cnt++;
         if (bus_a.x == 10'd100) found = 1'b1;
      end
      chk_int("reach_x100", int'(found), 1);
      for (int i = 0; i < 37; i++) begin
         step(0, 1'b0, "pause");
         cnt++;
         if (bus_a.x != 10'd100 || bus_a.pix_en || bus_a.line_start || bus_a.frame_start) bad++;
      end
      chk_int("pause_frozen", bad, 0);
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step(0, 1'b1, "to_next_line");
         cnt++;
         if (bus_a.line_start) found = 1'b1;
      end
      chk_int("paused_line_found", int'(found), 1);
      chk_int("paused_line_len", cnt, 1637);

      // Asynchronous reset between edges mid-line
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         step(0, 1'b1, "to_x300");
         if (bus_a.x == 10'd300) found = 1'b1;
      end
      chk_int("reach_x300", int'(found), 1);
      #2 rst_a = 1'b1;
      #1;
      model_reset(0);
      cmp_obs("async_reset", read_dut(0), '{1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      check_model(0, "reset_held");
      rst_a = 1'b0;
      run_table();

      // Randomised en against the reference model
      for (int i = 0; i < 20000; i++)
         step(0, ($urandom_range(0, 9) != 0), "rand_a");
      rst_a = 1'b1;

      // Small raster, CLK_DIV=1, active-high hsync
      @(negedge clk);
      check_model(1, "reset_b");
      rst_b = 1'b0;
      fs_cnt = 0; fs_prev = -1; fs_ival = 0; pix_bad = 0; hs_bad = 0; vs_bad = 0;
      for (int i = 0; i < 110; i++) begin
         step(1, 1'b1, "small");
         if (!bus_b.pix_en) pix_bad++;
         if (bus_b.hsync != (bus_b.x == 3'd5 || bus_b.x == 3'd6)) hs_bad++;
         if (bus_b.vsync != (bus_b.y != 3'd4)) vs_bad++;
         if (bus_b.frame_start) begin
            fs_cnt++;
            if (fs_prev >= 0) fs_ival = i - fs_prev;
            fs_prev = i;
         end
      end
      chk_int("small_pix_const", pix_bad, 0);
      chk_int("small_hsync", hs_bad, 0);
      chk_int("small_vsync", vs_bad, 0);
      chk_int("small_frames", fs_cnt, 3);
      chk_int("small_frame_period", fs_ival, 48);
      for (int i = 0; i < 5000; i++)
         step(1, bit'($urandom_range(0, 1)), "rand_b");
      rst_b = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_timing_gen.md
# pixel_timing_gen

Parametrised pixel-rate enable and raster timing generator for the VGA display path. Divides the system clock into a one-cycle pixel enable with a configurable ratio and advances horizontal/vertical position counters on each enable. Produces aligned hsync, vsync, video_on, x/y and line/frame start strobes for the game renderer and the VGA output stage. Replaces the fixed divide-by-2 pixel enable.

## Interface
- CLK_DIV, 2, clk cycles per pixel; legal range ≥1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels; ≥1
- H_SYNC, 96, hsync width in pixels; ≥1
- H_BP, 48, horizontal back porch in pixels; ≥1
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines; ≥1
- V_SYNC, 2, vsync width in lines; ≥1
- V_BP, 33, vertical back porch in lines; ≥1
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- X_W, 10, x width; must hold H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
- Y_W, 10, y width; must hold V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; 0 freezes all state
- pix_en  out  1  one-clk pixel enable pulse, period CLK_DIV
- x  out  X_W  horizontal position, 0..H_TOTAL-1
- y  out  Y_W  vertical position, 0..V_TOTAL-1
- video_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  out  1  horizontal sync at HS_POL level
- vsync  out  1  vertical sync at VS_POL level
- line_start  out  1  one-clk strobe on the first clk at x=0
- frame_start  out  1  one-clk strobe on the first clk at (0,0)

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1, wraps to 0, and steps only when en=1. On each edge, pix_en <= en && (div_cnt==CLK_DIV-1). With CLK_DIV=1, pix_en stays 1 while en=1.
- Position: on each edge with registered pix_en=1, x increments.
  - When x=H_TOTAL-1, x wraps to 0 and y increments.
  - When y=V_TOTAL-1 at that wrap, y wraps to 0.
- Horizontal regions: active 0..H_ACTIVE-1; front porch next H_FP pixels; sync next H_SYNC; back porch last H_BP.
  - hsync = HS_POL for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], otherwise ~HS_POL.
- Vertical regions follow the same scheme with the V_* parameters; vsync uses VS_POL.
- All outputs are registered and computed from next-state position, so x, y, video_on, hsync and vsync always describe the same pixel.
- line_start is high for the single clk following an advance into x=0. frame_start is high for the single clk following an advance into (0,0). Both are 0 otherwise.
- en=0: div_cnt, x, y and syncs hold; pix_en, line_start and frame_start are 0. On return to en=1, the divider phase resumes from the held div_cnt.
- Reset values (immediate on rst, no clock needed):
  - div_cnt=0, pix_en=0
  - x=H_TOTAL-1, y=V_TOTAL-1 (back-porch corner)
  - video_on=0, hsync=~HS_POL, vsync=~VS_POL
  - line_start=0, frame_start=0
- The first advance after reset therefore enters (0,0) with line_start and frame_start.
- Reset mid-frame discards the partial frame. No other recovery is performed.

## Timing
- pix_en first goes high after the CLK_DIV-th rising edge with en=1 following rst release. Subsequent pulses are 1 clk wide, every CLK_DIV clks.
- The first (0,0) position and strobes appear after edge CLK_DIV+1.
- Each position is held for exactly CLK_DIV clks.
  - Line period: H_TOTAL*CLK_DIV clks.
  - Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks.
- Defaults: 800 px/line, 525 lines, 1600 clk/line, 840000 clk/frame.
- Output latency from counter state: 0 extra cycles. No combinational path from any input to any output.

## Test plan
- Defaults, release rst, en=1 -> pix_en is 0 after edge 1, 1 after edge 2, then alternates. After edge 3: x=0, y=0, video_on=1, line_start=1, frame_start=1, each strobe for 1 clk.
- Defaults, one full line -> hsync=0 exactly for x=656..751 (192 clk). video_on=0 from x=640. line_start repeats every 1600 clk.
- Defaults, one full frame -> vsync=0 exactly for y=490..491 (3200 clk). frame_start occurs once per 840000 clk. y wraps 524->0.
- CLK_DIV=1, H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 -> pix_en constant 1, hsync=1 at x=5,6, vsync=0 at y=4, frame period 48 clk.
- Defaults, drop en for 37 clk at x=100 -> x, y and syncs frozen; pix_en and strobes 0. Resumes at x=100 with unchanged pix_en phase; line length grows by exactly 37 clk.
- Assert rst between edges mid-frame (x=300, y=200) -> x=799, y=524, video_on=0, hsync=1, vsync=1, pix_en=0 immediately. After release, the first-frame sequence repeats as in scenario 1.
